// File: rtl/core_exec_if.sv
// Execute-stage bus: operands, bypass sources and control from issue, results towards memory/fetch.
interface core_exec_if;
  logic [4:0]  i_rs1;
  logic [4:0]  i_rs2;
  logic [1:0]  i_bp_rs1;
  logic [1:0]  i_bp_rs2;
  logic [31:0] i_rs1_val;
  logic [31:0] i_rs2_val;
  logic [31:0] i_memory_rd_val;
  logic [31:0] i_write_rd_val;
  logic [31:0] i_write_back_rd_val;
  logic        i_alu_op1_sel;
  logic        i_alu_op2_sel;
  logic [29:0] i_pc;
  logic [31:0] i_imm;
  logic [4:0]  i_alu_ctrl;
  logic        i_jump;
  logic        i_branch;
  logic        i_pc_sel;
  logic [31:0] o_bp1;
  logic [31:0] o_bp2;
  logic [31:0] o_alu_result;
  logic        o_pc_src;
  logic [29:0] o_pc_target;

  modport master (
    output i_rs1, i_rs2, i_bp_rs1, i_bp_rs2, i_rs1_val, i_rs2_val,
           i_memory_rd_val, i_write_rd_val, i_write_back_rd_val,
           i_alu_op1_sel, i_alu_op2_sel, i_pc, i_imm, i_alu_ctrl,
           i_jump, i_branch, i_pc_sel,
    input  o_bp1, o_bp2, o_alu_result, o_pc_src, o_pc_target
  );

  modport slave (
    input  i_rs1, i_rs2, i_bp_rs1, i_bp_rs2, i_rs1_val, i_rs2_val,
           i_memory_rd_val, i_write_rd_val, i_write_back_rd_val,
           i_alu_op1_sel, i_alu_op2_sel, i_pc, i_imm, i_alu_ctrl,
           i_jump, i_branch, i_pc_sel,
    output o_bp1, o_bp2, o_alu_result, o_pc_src, o_pc_target
  );
endinterface

// File: rtl/core_exec_unit.sv
// RV32I execute stage: bypass muxing, operand selection, ALU, branch resolution and
// redirect target generation, with an optional register between operand prep and ALU.
module core_exec_unit #(
  parameter bit ALU_2_STAGE = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_flush,
  input  logic       i_stall,
  core_exec_if.slave bus
);

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] bp1;
    logic [31:0] bp2;
    logic [31:0] imm;
    logic [29:0] pc;
    logic [4:0]  alu_ctrl;
    logic        jump;
    logic        branch;
    logic        pc_sel;
  } stage_t;

  localparam int STAGE_W = $bits(stage_t);

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;
  localparam logic [4:0] ALU_PASS = 5'd10;
  localparam logic [4:0] ALU_EQ   = 5'd16;
  localparam logic [4:0] ALU_NE   = 5'd17;
  localparam logic [4:0] ALU_LT   = 5'd18;
  localparam logic [4:0] ALU_GE   = 5'd19;
  localparam logic [4:0] ALU_LTU  = 5'd20;
  localparam logic [4:0] ALU_GEU  = 5'd21;

  // x0 always reads as zero, whatever the forwarding select says
  function automatic logic [31:0] bypass_sel(
    input logic [4:0]  rs,
    input logic [1:0]  sel,
    input logic [31:0] rf_val,
    input logic [31:0] mem_val,
    input logic [31:0] wr_val,
    input logic [31:0] wb_val
  );
    logic [31:0] v;
    v = 32'd0;
    if (rs == 5'd0) begin
      v = 32'd0;
    end else begin
      case (sel)
        2'b00:   v = rf_val;
        2'b01:   v = mem_val;
        2'b10:   v = wr_val;
        2'b11:   v = wb_val;
        default: v = rf_val;
      endcase
    end
    return v;
  endfunction

  function automatic logic [31:0] alu_fn(
    input logic [4:0]  ctrl,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] r;
    r = 32'd0;
    case (ctrl)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SLT:  r = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: r = {31'd0, a < b};
      ALU_XOR:  r = a ^ b;
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   r = a | b;
      ALU_AND:  r = a & b;
      ALU_PASS: r = b;
      ALU_EQ:   r = {31'd0, a == b};
      ALU_NE:   r = {31'd0, a != b};
      ALU_LT:   r = {31'd0, $signed(a) < $signed(b)};
      ALU_GE:   r = {31'd0, $signed(a) >= $signed(b)};
      ALU_LTU:  r = {31'd0, a < b};
      ALU_GEU:  r = {31'd0, a >= b};
      default:  r = 32'd0;
    endcase
    return r;
  endfunction

  stage_t      prep_s;
  stage_t      stage_r;
  stage_t      stage_s;
  logic [31:0] result_s;
  logic [31:0] base_s;
  logic        carry_s;
  logic [29:0] target_s;

  // Operand preparation: bypass selection and operand muxing
  always_comb begin
    prep_s          = stage_t'({STAGE_W{1'b0}});
    prep_s.bp1      = bypass_sel(bus.i_rs1, bus.i_bp_rs1, bus.i_rs1_val, bus.i_memory_rd_val,
                                 bus.i_write_rd_val, bus.i_write_back_rd_val);
    prep_s.bp2      = bypass_sel(bus.i_rs2, bus.i_bp_rs2, bus.i_rs2_val, bus.i_memory_rd_val,
                                 bus.i_write_rd_val, bus.i_write_back_rd_val);
    prep_s.op1      = bus.i_alu_op1_sel ? {bus.i_pc, 2'b00} : prep_s.bp1;
    prep_s.op2      = bus.i_alu_op2_sel ? bus.i_imm : prep_s.bp2;
    prep_s.imm      = bus.i_imm;
    prep_s.pc       = bus.i_pc;
    prep_s.alu_ctrl = bus.i_alu_ctrl;
    prep_s.jump     = bus.i_jump;
    prep_s.branch   = bus.i_branch;
    prep_s.pc_sel   = bus.i_pc_sel;
  end

  // Prep-to-ALU stage register; reset, flush and stall all insert an all-zero bubble
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stage_r <= stage_t'({STAGE_W{1'b0}});
    end else if (i_flush) begin
      stage_r <= stage_t'({STAGE_W{1'b0}});
    end else if (i_stall) begin
      stage_r <= stage_t'({STAGE_W{1'b0}});
    end else begin
      stage_r <= prep_s;
    end
  end

  // In single-stage mode the register is left without a load and drops out in synthesis
  assign stage_s = ALU_2_STAGE ? stage_r : prep_s;

  // ALU and redirect target; only bits [31:2] of the target leave, so the low-bit add
  // is reduced to its carry into bit 2 (bit 0 is cleared and never reaches the output)
  always_comb begin
    result_s = alu_fn(stage_s.alu_ctrl, stage_s.op1, stage_s.op2);
    base_s   = stage_s.pc_sel ? stage_s.bp1 : {stage_s.pc, 2'b00};
    carry_s  = (base_s[1] & stage_s.imm[1]) |
               ((base_s[1] ^ stage_s.imm[1]) & base_s[0] & stage_s.imm[0]);
    target_s = base_s[31:2] + stage_s.imm[31:2] + {29'd0, carry_s};
  end

  assign bus.o_bp1        = stage_s.bp1;
  assign bus.o_bp2        = stage_s.bp2;
  assign bus.o_alu_result = result_s;
  assign bus.o_pc_src     = stage_s.jump | (stage_s.branch & result_s[0]);
  assign bus.o_pc_target  = target_s;

endmodule

// File: tb/tb_core_exec_unit.sv
// Directed-vector bench for core_exec_unit: one combinational and one two-stage instance
// share the same stimulus; the two-stage one is also exercised through reset/stall/flush.
module tb_core_exec_unit;

  localparam logic [4:0] ADD = 5'd0,  SUB = 5'd1,  SLL = 5'd2,  SLT = 5'd3,  SLTU = 5'd4;
  localparam logic [4:0] XOR = 5'd5,  SRL = 5'd6,  SRA = 5'd7,  OR  = 5'd8,  AND  = 5'd9;
  localparam logic [4:0] PASS = 5'd10, EQ = 5'd16, NE = 5'd17, LT = 5'd18, GE = 5'd19;
  localparam logic [4:0] LTU = 5'd20, GEU = 5'd21;
  localparam int NV = 27;

  typedef struct {
    logic [4:0]  rs1;  logic [1:0] s1; logic [31:0] v1;
    logic [4:0]  rs2;  logic [1:0] s2; logic [31:0] v2;
    logic [31:0] mem;  logic [31:0] wr; logic [31:0] wb;
    logic        o1s;  logic o2s; logic [29:0] pc; logic [31:0] imm; logic [4:0] ctrl;
    logic        jmp;  logic br; logic psel;
    logic [31:0] e_bp1; logic [31:0] e_bp2; logic [31:0] e_res; logic e_src; logic [29:0] e_tgt;
  } vec_t;

  logic i_clk;
  logic i_reset;
  logic i_flush;
  logic i_stall;
  int   n_checks;
  int   n_pass;
  vec_t vecs [0:NV-1];

  core_exec_if if0 ();
  core_exec_if if1 ();

  core_exec_unit #(.ALU_2_STAGE(1'b0)) u_comb (
    .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_stall(i_stall), .bus(if0)
  );
  core_exec_unit #(.ALU_2_STAGE(1'b1)) u_reg (
    .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_stall(i_stall), .bus(if1)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input vec_t v);
    if0.i_rs1 = v.rs1; if0.i_bp_rs1 = v.s1; if0.i_rs1_val = v.v1;
    if0.i_rs2 = v.rs2; if0.i_bp_rs2 = v.s2; if0.i_rs2_val = v.v2;
    if0.i_memory_rd_val = v.mem; if0.i_write_rd_val = v.wr; if0.i_write_back_rd_val = v.wb;
    if0.i_alu_op1_sel = v.o1s; if0.i_alu_op2_sel = v.o2s; if0.i_pc = v.pc; if0.i_imm = v.imm;
    if0.i_alu_ctrl = v.ctrl; if0.i_jump = v.jmp; if0.i_branch = v.br; if0.i_pc_sel = v.psel;
    if1.i_rs1 = v.rs1; if1.i_bp_rs1 = v.s1; if1.i_rs1_val = v.v1;
    if1.i_rs2 = v.rs2; if1.i_bp_rs2 = v.s2; if1.i_rs2_val = v.v2;
    if1.i_memory_rd_val = v.mem; if1.i_write_rd_val = v.wr; if1.i_write_back_rd_val = v.wb;
    if1.i_alu_op1_sel = v.o1s; if1.i_alu_op2_sel = v.o2s; if1.i_pc = v.pc; if1.i_imm = v.imm;
    if1.i_alu_ctrl = v.ctrl; if1.i_jump = v.jmp; if1.i_branch = v.br; if1.i_pc_sel = v.psel;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_reg(input string nm, input logic [31:0] res, input logic src,
                         input logic [29:0] tgt, input logic [31:0] bp1, input logic [31:0] bp2);
    chk({nm, " reg result"}, if1.o_alu_result, res);
    chk({nm, " reg pc_src"}, {31'd0, if1.o_pc_src}, {31'd0, src});
    chk({nm, " reg target"}, {2'd0, if1.o_pc_target}, {2'd0, tgt});
    chk({nm, " reg bp1"}, if1.o_bp1, bp1);
    chk({nm, " reg bp2"}, if1.o_bp2, bp2);
  endtask

  initial begin
    vec_t add34;
    n_checks = 0;
    n_pass   = 0;
    i_reset  = 1'b1;
    i_flush  = 1'b0;
    i_stall  = 1'b0;

    //          rs1  s1    v1            rs2  s2    v2           mem           wr            wb            o1s  o2s  pc           imm           ctrl jmp  br   psel   e_bp1         e_bp2         e_res         src  e_tgt
    vecs[0]  = '{5'd5, 2'b01, 32'h0000AAAA, 5'd0, 2'b00, 32'h12345678, 32'h00000010, 32'h0,        32'h0,        1'b0,1'b1,30'h0,       32'hFFFFFFFC, ADD, 1'b0,1'b0,1'b0, 32'h00000010, 32'h0,        32'h0000000C, 1'b0,30'h3FFFFFFF};
    vecs[1]  = '{5'd0, 2'b10, 32'h00000055, 5'd0, 2'b00, 32'h0,        32'h0,        32'h0000FFFF, 32'h0,        1'b0,1'b1,30'h0,       32'h00000007, ADD, 1'b0,1'b0,1'b0, 32'h0,        32'h0,        32'h00000007, 1'b0,30'h1};
    vecs[2]  = '{5'd1, 2'b00, 32'h80000000, 5'd2, 2'b00, 32'h00000001, 32'h0,        32'h0,        32'h0,        1'b0,1'b0,30'h40,      32'h00000020, LT,  1'b0,1'b1,1'b0, 32'h80000000, 32'h00000001, 32'h00000001, 1'b1,30'h48};
    vecs[3]  = '{5'd1, 2'b00, 32'h80000000, 5'd2, 2'b00, 32'h00000001, 32'h0,        32'h0,        32'h0,        1'b0,1'b0,30'h40,      32'h00000020, LTU, 1'b0,1'b1,1'b0, 32'h80000000, 32'h00000001, 32'h0,        1'b0,30'h48};
    vecs[4]  = '{5'd1, 2'b00, 32'h80000000, 5'd2, 2'b00, 32'h00000001, 32'h0,        32'h0,        32'h0,        1'b0,1'b1,30'h40,      32'h0000001F, SRA, 1'b0,1'b0,1'b0, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 1'b0,30'h47};
    vecs[5]  = '{5'd3, 2'b11, 32'h0,        5'd0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h00001003, 1'b1,1'b1,30'h40,      32'h0,        ADD, 1'b1,1'b0,1'b1, 32'h00001003, 32'h0,        32'h00000100, 1'b1,30'h400};
    vecs[6]  = '{5'd4, 2'b00, 32'h00000005, 5'd6, 2'b01, 32'h0,        32'h00000007, 32'h0,        32'h0,        1'b0,1'b0,30'h0,       32'h0,        SUB, 1'b0,1'b0,1'b0, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0,30'h0};
    vecs[7]  = '{5'd4, 2'b00, 32'h00000001, 5'd0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0,1'b1,30'h0,       32'h00000025, SLL, 1'b0,1'b0,1'b0, 32'h00000001, 32'h0,        32'h00000020, 1'b0,30'h9};
    vecs[8]  = '{5'd4, 2'b00, 32'hFFFFFFFF, 5'd6, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0,1'b0,30'h0,       32'h0,        SLT, 1'b0,1'b0,1'b0, 32'hFFFFFFFF, 32'h0,        32'h00000001, 1'b0,30'h0};
    vecs[9]  = '{5'd4, 2'b00, 32'hFFFFFFFF, 5'd6, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0,1'b0,30'h0,       32'h0,        SLTU,1'b0,1'b0,1'b0, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b0,30'h0};
    vecs[10] = '{5'd4, 2'b00, 32'hF0F0F0F0, 5'd6, 2'b10, 32'h0,        32'h0,        32'h0FF00FF0, 32'h0,        1'b0,1'b0,30'h0,       32'h0,        XOR, 1'b0,1'b0,1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0,30'h0};
    vecs[11] = '{5'd4, 2'b00, 32'hF0F0F0F0, 5'd6, 2'b10, 32'h0,        32'h0,        32'h0FF00FF0, 32'h0,        1'b0,1'b0,30'h0,       32'h0,        OR,  1'b0,1'b0,1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0,30'h0};
    vecs[12] = '{5'd4, 2'b00, 32'hF0F0F0F0, 5'd6, 2'b10, 32'h0,        32'h0,        32'h0FF00FF0, 32'h0,        1'b0,1'b0,30'h0,       32'h0,        AND, 1'b0,1'b0,1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0,30'h0};
    vecs[13] = '{5'd4, 2'b00, 32'h80000000, 5'd0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0,1'b1,30'h0,       32'h00000004, SRL, 1'b0,1'b0,1'b0, 32'h80000000, 32'h0,        32'h08000000, 1'b0,30'h1};
    vecs[14] = '{5'd0, 2'b00, 32'h11111111, 5'd0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0,        1'b1,1'b1,30'h40,      32'h12345000, PASS,1'b0,1'b0,1'b0, 32'h0,        32'h0,        32'h12345000, 1'b0,30'h048D1440};
    vecs[15] = '{5'd7, 2'b00, 32'h00000055, 5'd8, 2'b11, 32'h0,        32'h0,        32'h0,        32'h00000055, 1'b0,1'b0,30'h40,      32'h00000020, EQ,  1'b0,1'b1,1'b0, 32'h00000055, 32'h00000055, 32'h00000001, 1'b1,30'h48};
    vecs[16] = '{5'd7, 2'b00, 32'h00000055, 5'd8, 2'b11, 32'h0,        32'h0,        32'h0,        32'h00000055, 1'b0,1'b0,30'h40,      32'h00000020, NE,  1'b0,1'b1,1'b0, 32'h00000055, 32'h00000055, 32'h0,        1'b0,30'h48};
    vecs[17] = '{5'd1, 2'b00, 32'h80000000, 5'd2, 2'b00, 32'h00000001, 32'h0,        32'h0,        32'h0,        1'b0,1'b0,30'h40,      32'h00000020, GE,  1'b0,1'b1,1'b0, 32'h80000000, 32'h00000001, 32'h0,        1'b0,30'h48};
    vecs[18] = '{5'd1, 2'b00, 32'h80000000, 5'd2, 2'b00, 32'h00000001, 32'h0,        32'h0,        32'h0,        1'b0,1'b0,30'h40,      32'h00000020, GEU, 1'b0,1'b1,1'b0, 32'h80000000, 32'h00000001, 32'h00000001, 1'b1,30'h48};
    vecs[19] = '{5'd1, 2'b00, 32'h00000001, 5'd2, 2'b00, 32'h00000002, 32'h0,        32'h0,        32'h0,        1'b0,1'b0,30'h40,      32'h00000020, EQ,  1'b1,1'b1,1'b0, 32'h00000001, 32'h00000002, 32'h0,        1'b1,30'h48};
    vecs[20] = '{5'd1, 2'b00, 32'h00000005, 5'd2, 2'b00, 32'h00000003, 32'h0,        32'h0,        32'h0,        1'b0,1'b0,30'h0,       32'h0,        5'd11,1'b0,1'b1,1'b0, 32'h00000005, 32'h00000003, 32'h0,       1'b0,30'h0};
    vecs[21] = '{5'd1, 2'b00, 32'h00000005, 5'd2, 2'b00, 32'h00000003, 32'h0,        32'h0,        32'h0,        1'b0,1'b0,30'h0,       32'h0,        5'd31,1'b0,1'b1,1'b0, 32'h00000005, 32'h00000003, 32'h0,       1'b0,30'h0};
    vecs[22] = '{5'd5, 2'b11, 32'h0,        5'd0, 2'b11, 32'h0,        32'h0,        32'h0,        32'h0000DEAD, 1'b0,1'b0,30'h0,       32'h0,        ADD, 1'b0,1'b0,1'b0, 32'h0000DEAD, 32'h0,        32'h0000DEAD, 1'b0,30'h0};
    vecs[23] = '{5'd0, 2'b00, 32'h0,        5'd0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0,        1'b1,1'b1,30'h3FFFFFFF,32'h00000008, ADD, 1'b0,1'b0,1'b0, 32'h0,        32'h0,        32'h00000004, 1'b0,30'h1};
    vecs[24] = '{5'd9, 2'b00, 32'h00000003, 5'd0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0,1'b1,30'h0,       32'h00000001, ADD, 1'b1,1'b0,1'b1, 32'h00000003, 32'h0,        32'h00000004, 1'b1,30'h1};
    vecs[25] = '{5'd9, 2'b00, 32'h00000002, 5'd0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0,1'b1,30'h0,       32'h00000002, ADD, 1'b1,1'b0,1'b1, 32'h00000002, 32'h0,        32'h00000004, 1'b1,30'h1};
    vecs[26] = '{5'd31,2'b00, 32'h0000CAFE, 5'd31,2'b01, 32'h0,        32'h0000BEEF, 32'h0,        32'h0,        1'b0,1'b0,30'h0,       32'h0,        ADD, 1'b0,1'b0,1'b0, 32'h0000CAFE, 32'h0000BEEF, 32'h000189ED, 1'b0,30'h0};

    add34 = '{5'd1, 2'b00, 32'h3, 5'd2, 2'b00, 32'h4, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 30'h0,
              32'h0, ADD, 1'b0, 1'b0, 1'b0, 32'h3, 32'h4, 32'h7, 1'b0, 30'h0};

    // Reset with a live jump on the inputs: the registered instance must stay all-zero
    drive(vecs[5]);
    tick();
    tick();
    chk_reg("reset", 32'h0, 1'b0, 30'h0, 32'h0, 32'h0);
    i_reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d comb bp1", i), if0.o_bp1, vecs[i].e_bp1);
      chk($sformatf("v%0d comb bp2", i), if0.o_bp2, vecs[i].e_bp2);
      chk($sformatf("v%0d comb result", i), if0.o_alu_result, vecs[i].e_res);
      chk($sformatf("v%0d comb pc_src", i), {31'd0, if0.o_pc_src}, {31'd0, vecs[i].e_src});
      chk($sformatf("v%0d comb target", i), {2'd0, if0.o_pc_target}, {2'd0, vecs[i].e_tgt});
      tick();
      chk_reg($sformatf("v%0d", i), vecs[i].e_res, vecs[i].e_src, vecs[i].e_tgt,
              vecs[i].e_bp1, vecs[i].e_bp2);
    end

    // One-cycle latency: new inputs are not visible until the next edge
    drive(add34);
    #1;
    chk("latency hold result", if1.o_alu_result, vecs[NV-1].e_res);
    tick();
    chk_reg("add34", 32'h7, 1'b0, 30'h0, 32'h3, 32'h4);

    // Stall loads a bubble even with a jump on the inputs
    add34.jmp = 1'b1;
    drive(add34);
    i_stall = 1'b1;
    tick();
    chk_reg("stall", 32'h0, 1'b0, 30'h0, 32'h0, 32'h0);
    i_stall = 1'b0;
    tick();
    chk("after stall pc_src", {31'd0, if1.o_pc_src}, 32'h1);

    // Flush discards the JALR; releasing it lets the same inputs through
    drive(vecs[5]);
    i_flush = 1'b1;
    tick();
    chk_reg("flush", 32'h0, 1'b0, 30'h0, 32'h0, 32'h0);
    i_flush = 1'b0;
    tick();
    chk_reg("after flush", 32'h100, 1'b1, 30'h400, 32'h1003, 32'h0);

    // Reset mid-operation drops the in-flight instruction
    i_reset = 1'b1;
    tick();
    chk_reg("mid reset", 32'h0, 1'b0, 30'h0, 32'h0, 32'h0);
    i_reset = 1'b0;
    tick();
    chk("after reset target", {2'd0, if1.o_pc_target}, {2'd0, 30'h400});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
